hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. Watches ID, ID/EX and the data-memory handshake;
//  drives PC/IF-ID write enables and IF/ID, ID/EX flushes. Resolves load-use and jr hazards,
//  squashes wrong-path work on EX-stage branches and ID-stage jumps, and freezes the pipe on
//  memory wait with timeout. Keeps stall/flush performance counters.
// PARAMETERS
//  MEM_TIMEOUT   64   max consecutive dmem wait cycles before mem_err is raised (>=2)
//  CNT_W         32   width of performance counters
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high reset
//  id_rs        in   5      rs field of instruction in ID
//  id_rt        in   5      rt field of instruction in ID
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  id_jump      in   1      ID holds j/jal (target known in ID)
//  id_jr        in   1      ID holds jr/jalr (needs rs value in ID)
//  ex_memread   in   1      ID/EX MemRead
//  ex_regwrite  in   1      ID/EX RegWrite
//  ex_wreg      in   5      destination register of EX instruction (post-RegDst)
//  ex_br_taken  in   1      branch in EX resolved taken this cycle
//  mem_req      in   1      MEM stage issuing a dmem access
//  mem_ready    in   1      dmem completes access this cycle
//  pc_write     out  1      PC update enable
//  ifid_write   out  1      IF/ID load enable
//  ifid_flush   out  1      IF/ID clear (becomes nop)
//  idex_flush   out  1      ID/EX clear (bubble)
//  pipe_freeze  out  1      hold ID/EX, EX/MEM, MEM/WB
//  mem_err      out  1      sticky dmem timeout flag
//  stall_cnt    out  CNT_W  cycles with pc_write=0
//  flush_cnt    out  CNT_W  cycles with ifid_flush|idex_flush=1
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_err=0, counters=0. Outputs combinational from state+inputs;
//   during reset pc_write=ifid_write=1, flushes=0, pipe_freeze=0.
//  Hazard terms (rN=0 never hazards): dep = ex_regwrite & ex_wreg!=0 &
//   ((id_use_rs&ex_wreg==id_rs)|(id_use_rt&ex_wreg==id_rt)); lu = dep & ex_memread;
//   jrdep = id_jr & ex_regwrite & ex_wreg!=0 & ex_wreg==id_rs.
//  FSM states RUN, JR_WAIT, MEM_WAIT. Priority per cycle, highest first:
//   1 MEM_WAIT, or RUN with mem_req&!mem_ready: pipe_freeze=1, pc_write=ifid_write=0, no flush;
//     enter/stay MEM_WAIT, wait_cnt++; on mem_ready -> RUN, wait_cnt=0 (release cycle frozen).
//     wait_cnt==MEM_TIMEOUT-1 without ready: mem_err=1 (sticky to reset), -> RUN, wait_cnt=0.
//   2 ex_br_taken: ifid_flush=1, idex_flush=1, pc_write=1; cancels any JR_WAIT -> RUN.
//   3 JR_WAIT: pc_write=ifid_write=0, idex_flush=1; -> RUN next cycle.
//   4 jrdep: stall 1 cycle (pc_write=ifid_write=0, idex_flush=1); if also ex_memread -> JR_WAIT
//     (2 stall cycles total), else stay RUN.
//   5 lu: pc_write=ifid_write=0, idex_flush=1 (one bubble).
//   6 id_jump: ifid_flush=1, pc_write=1.
//   7 else all enables 1, flushes 0.
//  ex_br_taken with mem stall pending: freeze wins; branch acted on when released (EX held).
//  Counters increment per qualifying cycle, saturate at all-ones; not counted during reset.
//  Reset mid-operation: asynchronously returns to RUN, clears wait_cnt, mem_err, counters.
// TESTING
//  ex_memread=1,ex_regwrite=1,ex_wreg=8; id_rs=8,id_use_rs=1 -> 1 cycle pc_write=0, idex_flush=1; stall_cnt=1.
//  Same with id_jr=1 -> 2 stall cycles (RUN->JR_WAIT->RUN); ex_wreg=0 -> no stall.
//  ex_br_taken=1 together with lu and id_jump -> ifid_flush=idex_flush=1, pc_write=1; flush_cnt+1.
//  mem_req=1, mem_ready low 3 cycles then high -> pipe_freeze=1 for 4 cycles, back to RUN, mem_err=0.
//  MEM_TIMEOUT=4, mem_ready never -> mem_err=1 after 4 freeze cycles, stays 1 until reset.
//  reset pulse in JR_WAIT/MEM_WAIT -> next cycle RUN, counters=0, all enables 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use / jr stalls, branch and jump
// squash, data-memory freeze with timeout, and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_JR_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_mem_err;
    logic                w_err_set;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_ex_wr;
    logic w_dep;
    logic w_lu;
    logic w_jrdep;
    logic w_mem_stall;

    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_pipe_freeze;

    // Hazard terms; register 0 never carries a dependency.
    assign w_ex_wr     = ex_regwrite && (ex_wreg != 5'd0);
    assign w_dep       = w_ex_wr && ((id_use_rs && (ex_wreg == id_rs)) ||
                                     (id_use_rt && (ex_wreg == id_rt)));
    assign w_lu        = w_dep && ex_memread;
    assign w_jrdep     = id_jr && w_ex_wr && (ex_wreg == id_rs);
    assign w_mem_stall = (r_state == ST_MEM_WAIT) ||
                         ((r_state == ST_RUN) && mem_req && !mem_ready);

    // Next-state and control outputs, highest priority first.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_pipe_freeze = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_err_set     = 1'b0;

        if (w_mem_stall) begin
            w_pipe_freeze = 1'b1;
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            if ((r_state == ST_MEM_WAIT) && mem_ready) begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end else if (r_wait_cnt == WAIT_LAST) begin
                w_err_set   = 1'b1;
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end else begin
                w_state_nxt = ST_MEM_WAIT;
                w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
            end
        end else if (ex_br_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_state_nxt  = ST_RUN;
        end else if (r_state == ST_JR_WAIT) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            w_state_nxt  = ST_RUN;
        end else if (w_jrdep) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            // A jr behind a load needs a second bubble before rs is available.
            if (ex_memread) begin
                w_state_nxt = ST_JR_WAIT;
            end
        end else if (w_lu) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
        end else if (id_jump) begin
            w_ifid_flush = 1'b1;
        end
    end

    // State, wait counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((w_ifid_flush || w_idex_flush) && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // While reset is held the pipe runs free regardless of hazard inputs.
    assign pc_write    = reset || w_pc_write;
    assign ifid_write  = reset || w_ifid_write;
    assign ifid_flush  = !reset && w_ifid_flush;
    assign idex_flush  = !reset && w_idex_flush;
    assign pipe_freeze = !reset && w_pipe_freeze;
    assign mem_err     = r_mem_err;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazard priorities, jr/load double stall, memory freeze,
// timeout, async reset mid-operation and counter saturation.
module tb_hazard_ctrl;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 8;
    localparam int          CNT_SAT = 255;

    logic          clk;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_wreg;
    logic          id_use_rs, id_use_rt, id_jump, id_jr;
    logic          ex_memread, ex_regwrite, ex_br_taken, mem_req, mem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [4:0]    outs;

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .id_jr(id_jr),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
    assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_jump = 1'b0; id_jr = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;
        ex_wreg = 5'd0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    // Check combinational outputs for this cycle, account counters, advance one clock.
    task automatic step(input string tag, input logic [4:0] exp);
        #1;
        check(tag, 32'(outs), 32'(exp));
        if (!exp[4] && exp_stall < CNT_SAT) exp_stall++;
        if ((exp[2] || exp[1]) && exp_flush < CNT_SAT) exp_flush++;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_cnt(input string tag);
        check({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check({tag, "_outs"}, 32'(outs), 32'(5'b11000));
        check({tag, "_err"}, 32'(mem_err), 32'd0);
        chk_cnt(tag);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_lu();
        #3;
        check("rst_outs", 32'(outs), 32'(5'b11000));
        check("rst_err", 32'(mem_err), 32'd0);
        chk_cnt("rst");
        repeat (2) @(posedge clk);
        #2;
        chk_cnt("rst_hold");
        reset = 1'b0;
        idle();

        step("idle", 5'b11000);

        set_lu();
        step("lu_rs", 5'b00010);
        idle();
        step("lu_after", 5'b11000);
        chk_cnt("lu");

        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
        id_rt = 5'd8; id_use_rt = 1'b1;
        step("lu_rt", 5'b00010);
        ex_memread = 1'b0;
        step("dep_no_load", 5'b11000);
        ex_memread = 1'b1; ex_wreg = 5'd0; id_rt = 5'd0;
        step("r0_no_haz", 5'b11000);
        idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8;
        step("unused_rs", 5'b11000);

        idle(); set_lu(); id_jr = 1'b1;
        step("jr_ld_1", 5'b00010);
        idle();
        step("jr_ld_2", 5'b00010);
        step("jr_ld_done", 5'b11000);
        chk_cnt("jr_ld");

        ex_regwrite = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_jr = 1'b1;
        step("jr_alu", 5'b00010);
        idle();
        step("jr_alu_done", 5'b11000);

        set_lu(); id_jump = 1'b1; ex_br_taken = 1'b1;
        step("br_over_all", 5'b11110);
        idle(); id_jump = 1'b1;
        step("jump", 5'b11100);
        idle();
        chk_cnt("br_jump");

        set_lu(); id_jr = 1'b1;
        step("jr_cancel_1", 5'b00010);
        idle(); ex_br_taken = 1'b1;
        step("jr_cancel_br", 5'b11110);
        idle();
        step("jr_cancel_run", 5'b11000);

        mem_req = 1'b1;
        step("mem_w1", 5'b00001);
        ex_br_taken = 1'b1;
        step("mem_w2_br", 5'b00001);
        ex_br_taken = 1'b0;
        step("mem_w3", 5'b00001);
        mem_ready = 1'b1;
        step("mem_rel", 5'b00001);
        idle();
        step("mem_run", 5'b11000);
        check("mem_no_err", 32'(mem_err), 32'd0);
        chk_cnt("mem");

        mem_req = 1'b1;
        step("to_w1", 5'b00001);
        step("to_w2", 5'b00001);
        step("to_w3", 5'b00001);
        check("to_err_early", 32'(mem_err), 32'd0);
        step("to_w4", 5'b00001);
        check("to_err_set", 32'(mem_err), 32'd1);
        idle();
        step("to_run", 5'b11000);
        step("to_run2", 5'b11000);
        check("to_err_sticky", 32'(mem_err), 32'd1);
        chk_cnt("to");

        set_lu(); id_jr = 1'b1;
        step("rst_jr_enter", 5'b00010);
        idle();
        pulse_reset("rst_jr");
        step("rst_jr_run", 5'b11000);

        mem_req = 1'b1;
        step("rst_mem_enter", 5'b00001);
        idle();
        pulse_reset("rst_mem");
        step("rst_mem_run", 5'b11000);
        chk_cnt("post_rst");

        set_lu();
        for (int i = 0; i < 300; i++) begin
            step("sat_lu", 5'b00010);
        end
        idle();
        chk_cnt("sat");
        check("sat_max", 32'(stall_cnt), 32'(CNT_SAT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
